ps2_jump_rx: RTL

PS2_JUMP_RX -- requirements
Module: ps2_jump_rx

---
 rtl/ps2_jump_rx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ps2_jump_rx.sv
// PS/2 keyboard receiver that decodes space / up-arrow make and break codes
// into an active-low jump level for the game core.
module ps2_jump_rx #(
  parameter int unsigned FILTER_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC   = 50000,
  parameter logic [7:0]  JUMP_CODE     = 8'h29,
  parameter logic [7:0]  JUMP_EXT_CODE = 8'h75
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       jump,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] filt_cnt_q;
  logic          fall;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout, accept, perr_d, ferr_d;

  logic          ext_q, ext_d, brk_q, brk_d;
  logic          ps_q, ps_d, pu_q, pu_d;

  // Synchronizers and the glitch filter on ps2_clk.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_prev_q <= filt_q;
      if (clk_s2_q != filt_q) begin
        if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q     <= clk_s2_q;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    accept    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    tmo_d     = (state_q == StIdle || fall) ? '0 : tmo_q + 1'b1;
    timeout   = (state_q != StIdle) && !fall && (tmo_q == TW'(TIMEOUT_CYC - 1));
    unique case (state_q)
      StIdle: begin
        if (fall && !dat_s2_q) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fall) begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          // A bad stop bit masks any parity failure.
          if (!dat_s2_q)              ferr_d = 1'b1;
          else if (^{shreg_q, par_q}) accept = 1'b1;
          else                        perr_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      state_d = StIdle;
      ferr_d  = 1'b1;
    end
  end

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    ps_d  = ps_q;
    pu_d  = pu_q;
    if (accept) begin
      if (shreg_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shreg_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (!ext_q && shreg_q == JUMP_CODE)    ps_d = ~brk_q;
        if (ext_q && shreg_q == JUMP_EXT_CODE) pu_d = ~brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      ps_q       <= 1'b0;
      pu_q       <= 1'b0;
      jump       <= 1'b1;
      scan_code  <= 8'h00;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      ps_q       <= ps_d;
      pu_q       <= pu_d;
      jump       <= ~(ps_d | pu_d);
      if (accept) scan_code <= shreg_q;
      code_valid <= accept;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
    end
  end

endmodule
